// File: rtl/tv80_bus_responder_pkg.sv
// Shared definitions for TV80 bus-side target blocks: FSM encodings, defaults, strobe decode.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package tv80_bus_responder_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_STRETCH = 3'd2,
        ST_DONE    = 3'd3,
        ST_ABORT   = 3'd4
    } state_e;

    localparam byte_t IDLE_DATA_DFLT = 8'hFF;

    // Backend command captured when a CPU access starts; held stable for the whole request.
    typedef struct packed {
        logic        we;
        logic        io;
        logic [15:0] addr;
        byte_t       wdata;
    } bk_cmd_t;

    // A real memory or I/O read/write. Refresh (mreq with rfsh low) is excluded, and
    // iorq together with m1 is an interrupt acknowledge, not an I/O access.
    function automatic logic cpu_strobe(input logic mreq_n, input logic iorq_n,
                                        input logic rd_n, input logic wr_n,
                                        input logic rfsh_n, input logic m1_n);
        return ((~mreq_n & rfsh_n) | (~iorq_n & m1_n)) & (~rd_n | ~wr_n);
    endfunction

    function automatic logic cpu_intack(input logic iorq_n, input logic m1_n);
        return ~iorq_n & ~m1_n;
    endfunction

endpackage

// File: rtl/tv80_bus_responder_irq_ctl.sv
// Interrupt control: irq rising-edge detect, pending flag driving int_n, IM2 vector capture.
// Latency: int_n falls one clock after the irq edge is sampled; vector valid one clock after ack.
// Backpressure: none; an edge coinciding with the acknowledge clear keeps the request pending.
// Ports: irq_i/irq_vec_i from the SoC, ack_i from the bus FSM (int-ack detected in IDLE),
//        int_n_o to the CPU, vec_o captured vector for the read-data mux.
module tv80_bus_responder_irq_ctl
    import tv80_bus_responder_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  irq_i,
    input  byte_t irq_vec_i,
    input  logic  ack_i,
    output logic  int_n_o,
    output byte_t vec_o
);

    logic  irq_q;
    logic  pending_q, pending_d;
    byte_t vec_q, vec_d;

    always_comb begin
        // Set has priority over the acknowledge clear so a fresh edge is never lost.
        pending_d = (irq_i & ~irq_q) | (pending_q & ~ack_i);
        vec_d     = ack_i ? irq_vec_i : vec_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q     <= 1'b0;
            pending_q <= 1'b0;
            vec_q     <= '0;
        end else begin
            irq_q     <= irq_i;
            pending_q <= pending_d;
            vec_q     <= vec_d;
        end
    end

    assign int_n_o = ~pending_q;
    assign vec_o   = vec_q;

endmodule

// File: rtl/tv80_bus_responder.sv
// TV80 external-bus target: turns CPU memory/I/O cycles into backend req/ack transactions.
// Latency: wait_n low from the first strobe clock until backend ack, plus MIN_WAIT clocks.
// Backpressure: CPU stalled via wait_n; bk_req held until bk_ack, no new request meanwhile.
// Ports: CPU pins (m1_n/mreq_n/iorq_n/rd_n/wr_n/rfsh_n/a/cpu_dout in, cpu_di/wait_n/int_n out),
//        irq_i/irq_vec_i interrupt source, bk_* synchronous backend request/ack port.
module tv80_bus_responder
    import tv80_bus_responder_pkg::*;
#(
    parameter int unsigned MIN_WAIT  = 0,
    parameter byte_t       IDLE_DATA = IDLE_DATA_DFLT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m1_n_i,
    input  logic        mreq_n_i,
    input  logic        iorq_n_i,
    input  logic        rd_n_i,
    input  logic        wr_n_i,
    input  logic        rfsh_n_i,
    input  logic [15:0] a_i,
    input  logic [7:0]  cpu_dout_i,
    output logic [7:0]  cpu_di_o,
    output logic        wait_n_o,
    output logic        int_n_o,
    input  logic        irq_i,
    input  logic [7:0]  irq_vec_i,
    output logic        bk_req_o,
    output logic        bk_we_o,
    output logic        bk_io_o,
    output logic [15:0] bk_addr_o,
    output logic [7:0]  bk_wdata_o,
    input  logic        bk_ack_i,
    input  logic [7:0]  bk_rdata_i
);

    localparam logic [3:0] STRETCH_LOAD = 4'(MIN_WAIT);

    state_e     state_q, state_d;
    bk_cmd_t    cmd_q, cmd_d;
    logic       bk_req_q, bk_req_d;
    byte_t      cpu_di_q, cpu_di_d;
    logic       di_vec_q, di_vec_d;
    logic [3:0] cnt_q, cnt_d;

    logic       strobe;
    logic       intack;
    logic       cmd_load;
    logic       ack_take;
    logic       rd_load;
    logic       vec_load;
    logic       stretch_load;
    logic       di_clr;
    byte_t      vec;

    assign strobe = cpu_strobe(mreq_n_i, iorq_n_i, rd_n_i, wr_n_i, rfsh_n_i, m1_n_i);
    assign intack = cpu_intack(iorq_n_i, m1_n_i);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    state_d = ST_REQ;
                end else if (intack) begin
                    state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                // An ack in the same clock the strobe vanishes closes the transaction
                // outright; waiting in ABORT for a second ack would never end.
                if (bk_ack_i) begin
                    if (!strobe) begin
                        state_d = ST_IDLE;
                    end else if (MIN_WAIT > 0) begin
                        state_d = ST_STRETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (!strobe) begin
                    state_d = ST_ABORT;
                end
            end
            ST_STRETCH: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!strobe && !intack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (bk_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs and datapath controls ----------------
    always_comb begin
        // Combinational so the CPU sees wait low in the very T-state the strobe appears;
        // all inputs come straight from CPU flops, so no loop is formed.
        wait_n_o     = ~((strobe & (state_q != ST_DONE)) | (state_q == ST_STRETCH));
        cmd_load     = (state_q == ST_IDLE) & strobe;
        ack_take     = bk_ack_i & ((state_q == ST_REQ) | (state_q == ST_ABORT));
        rd_load      = (state_q == ST_REQ) & bk_ack_i & strobe & ~cmd_q.we;
        vec_load     = (state_q == ST_IDLE) & ~strobe & intack;
        stretch_load = (state_q == ST_REQ) & (state_d == ST_STRETCH);
        di_clr       = (state_q == ST_DONE) & (state_d == ST_IDLE);
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        cmd_d    = cmd_q;
        bk_req_d = bk_req_q;
        cpu_di_d = cpu_di_q;
        di_vec_d = di_vec_q;
        cnt_d    = cnt_q;

        if (cmd_load) begin
            cmd_d.we    = ~wr_n_i;
            cmd_d.io    = ~iorq_n_i;
            cmd_d.addr  = a_i;
            cmd_d.wdata = cpu_dout_i;
            bk_req_d    = 1'b1;
        end
        if (ack_take) begin
            bk_req_d = 1'b0;
        end
        if (rd_load) begin
            cpu_di_d = bk_rdata_i;
        end
        if (vec_load) begin
            di_vec_d = 1'b1;
        end
        if (di_clr) begin
            cpu_di_d = IDLE_DATA;
            di_vec_d = 1'b0;
        end
        if (stretch_load) begin
            cnt_d = STRETCH_LOAD;
        end else if (state_q == ST_STRETCH) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q    <= '0;
            bk_req_q <= 1'b0;
            cpu_di_q <= IDLE_DATA;
            di_vec_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cmd_q    <= cmd_d;
            bk_req_q <= bk_req_d;
            cpu_di_q <= cpu_di_d;
            di_vec_q <= di_vec_d;
            cnt_q    <= cnt_d;
        end
    end

    tv80_bus_responder_irq_ctl u_irq_ctl (
        .clk       (clk),
        .reset_n   (reset_n),
        .irq_i     (irq_i),
        .irq_vec_i (irq_vec_i),
        .ack_i     (vec_load),
        .int_n_o   (int_n_o),
        .vec_o     (vec)
    );

    // The vector lives in the irq block; a flag selects it during int-ack so cpu_di stays registered.
    assign cpu_di_o   = di_vec_q ? vec : cpu_di_q;
    assign bk_req_o   = bk_req_q;
    assign bk_we_o    = cmd_q.we;
    assign bk_io_o    = cmd_q.io;
    assign bk_addr_o  = cmd_q.addr;
    assign bk_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_tv80_bus_responder.sv
// Bench for tv80_bus_responder: CPU pin driver, backend device model and expected-result queue.
// Latency: expected wait count per access is 1 (strobe clock) + (ack latency + 1) + MW.
// Backpressure: backend acks a programmable number of clocks after bk_req.
module tb_tv80_bus_responder;

    localparam int MW = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
    logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
    logic [15:0] a = '0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_di;
    logic        wait_n, int_n;
    logic        irq = 1'b0;
    logic [7:0]  irq_vec = '0;
    logic        bk_req, bk_we, bk_io;
    logic [15:0] bk_addr;
    logic [7:0]  bk_wdata;
    logic        bk_ack = 1'b0;
    logic [7:0]  bk_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          lat;
        int          waits;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [int];
    logic [7:0] dev_mem [int];

    tv80_bus_responder #(.MIN_WAIT(MW), .IDLE_DATA(8'hFF)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m1_n_i     (m1_n),
        .mreq_n_i   (mreq_n),
        .iorq_n_i   (iorq_n),
        .rd_n_i     (rd_n),
        .wr_n_i     (wr_n),
        .rfsh_n_i   (rfsh_n),
        .a_i        (a),
        .cpu_dout_i (cpu_dout),
        .cpu_di_o   (cpu_di),
        .wait_n_o   (wait_n),
        .int_n_o    (int_n),
        .irq_i      (irq),
        .irq_vec_i  (irq_vec),
        .bk_req_o   (bk_req),
        .bk_we_o    (bk_we),
        .bk_io_o    (bk_io),
        .bk_addr_o  (bk_addr),
        .bk_wdata_o (bk_wdata),
        .bk_ack_i   (bk_ack),
        .bk_rdata_i (bk_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang want completion");
        $fatal(1, "watchdog");
    end

    function automatic int mk_key(input logic io, input logic [15:0] addr);
        return int'({15'd0, io, addr});
    endfunction

    function automatic logic [7:0] seed_val(input int key);
        logic [7:0] v;
        v = 8'(key) ^ 8'(key >> 8) ^ 8'h5A;
        return v;
    endfunction

    function automatic logic [7:0] ref_rd(input int key);
        return ref_mem.exists(key) ? ref_mem[key] : seed_val(key);
    endfunction

    function automatic logic [7:0] dev_rd(input int key);
        return dev_mem.exists(key) ? dev_mem[key] : seed_val(key);
    endfunction

    task automatic idle_pins();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    // Push the expected outcome, then start the CPU cycle just after the next rising edge.
    task automatic drive_access(input logic io, input logic we, input logic [15:0] addr,
                                input logic [7:0] wdata, input int lat);
        exp_t e;
        int   key;
        key     = mk_key(io, addr);
        e.we    = we;
        e.io    = io;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = we ? 8'hFF : ref_rd(key);
        e.lat   = lat;
        e.waits = 1 + (lat + 1) + MW;
        if (we) ref_mem[key] = wdata;
        exp_q.push_back(e);
        @(posedge clk); #1;
        m1_n = 1'b1; rfsh_n = 1'b1;
        mreq_n = io; iorq_n = ~io;
        rd_n = we; wr_n = ~we;
        a = addr; cpu_dout = wdata;
    endtask

    // Play the backend, count wait clocks, then compare against the popped expectation.
    task automatic finish_access(input string tag, input bit chk_wait);
        exp_t e;
        int   k = 0;
        int   waits = 0;
        int   key;
        bit   acked = 0;
        bit   done = 0;
        e = exp_q.pop_front();
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            bk_ack = 1'b0;
            if (bk_req === 1'b1 && !acked) begin
                if (k == 0) begin
                    checks++;
                    if ({bk_we, bk_io, bk_addr, bk_wdata} !== {e.we, e.io, e.addr, e.wdata}) begin
                        errors++;
                        $display("FAIL %s bk_cmd: got we=%0b io=%0b addr=%h wdata=%h want we=%0b io=%0b addr=%h wdata=%h",
                                 tag, bk_we, bk_io, bk_addr, bk_wdata, e.we, e.io, e.addr, e.wdata);
                    end
                end
                if (k == e.lat) begin
                    key      = mk_key(bk_io, bk_addr);
                    bk_ack   = 1'b1;
                    bk_rdata = dev_rd(key);
                    if (bk_we) dev_mem[key] = bk_wdata;
                    acked    = 1;
                end
                k++;
            end
            if (wait_n === 1'b0) waits++;
            else if (wait_n === 1'b1) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: wait_n never released within 60 clocks", tag);
        end else begin
            if (chk_wait) begin
                checks++;
                if (waits != e.waits) begin
                    errors++;
                    $display("FAIL %s wait_count: got %0d want %0d", tag, waits, e.waits);
                end
            end
            if (cpu_di !== e.rdata) begin
                errors++;
                $display("FAIL %s cpu_di: got %h want %h", tag, cpu_di, e.rdata);
            end
        end
        @(posedge clk); #1;
        idle_pins();
        bk_ack = 1'b0;
    endtask

    task automatic wait_bk_req(input string tag);
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bk_req === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s bk_req_timeout: got no request want bk_req=1", tag);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_di, wait_n, int_n, bk_req} !== {8'hFF, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_cpu_side: got di=%h wait_n=%b int_n=%b bk_req=%b want di=ff wait_n=1 int_n=1 bk_req=0",
                     cpu_di, wait_n, int_n, bk_req);
        end
        checks++;
        if ({bk_we, bk_io, bk_addr, bk_wdata} !== 26'd0) begin
            errors++;
            $display("FAIL reset_bk_side: got we=%b io=%b addr=%h wdata=%h want all zero",
                     bk_we, bk_io, bk_addr, bk_wdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mem_read();
        ref_mem[mk_key(1'b0, 16'h1234)] = 8'hA5;
        dev_mem[mk_key(1'b0, 16'h1234)] = 8'hA5;
        // Ack sampled three edges after bk_req rises.
        drive_access(1'b0, 1'b0, 16'h1234, 8'h00, 2);
        finish_access("mem_read", 1);
    endtask

    task automatic test_io_write();
        drive_access(1'b1, 1'b1, 16'h007F, 8'h3C, 0);
        finish_access("io_write", 1);
        checks++;
        if (dev_rd(mk_key(1'b1, 16'h007F)) !== 8'h3C) begin
            errors++;
            $display("FAIL io_write_dev: got %h want 3c", dev_rd(mk_key(1'b1, 16'h007F)));
        end
    endtask

    task automatic test_refresh();
        drive_access(1'b0, 1'b0, 16'h0100, 8'h00, 1);
        finish_access("pre_refresh", 1);
        @(posedge clk); #1;
        m1_n = 1'b1; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; a = 16'h0042;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({wait_n, bk_req} !== 2'b10) begin
                errors++;
                $display("FAIL refresh: got wait_n=%b bk_req=%b want wait_n=1 bk_req=0", wait_n, bk_req);
            end
        end
        @(posedge clk); #1;
        idle_pins();
        drive_access(1'b0, 1'b0, 16'h0101, 8'h00, 0);
        finish_access("post_refresh", 1);
    endtask

    task automatic test_irq();
        @(posedge clk); #1;
        irq_vec = 8'hE8; irq = 1'b1;
        @(posedge clk); #1;
        irq = 1'b0;
        @(negedge clk);
        checks++;
        if (int_n !== 1'b0) begin errors++; $display("FAIL irq_assert: got int_n=%b want 0", int_n); end
        repeat (2) @(negedge clk);
        checks++;
        if (int_n !== 1'b0) begin errors++; $display("FAIL irq_hold: got int_n=%b want 0", int_n); end
        @(posedge clk); #1;
        m1_n = 1'b0; iorq_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({wait_n, bk_req} !== 2'b10) begin
            errors++;
            $display("FAIL intack_nowait: got wait_n=%b bk_req=%b want wait_n=1 bk_req=0", wait_n, bk_req);
        end
        @(negedge clk);
        checks++;
        if ({cpu_di, int_n, bk_req} !== {8'hE8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL intack_vec: got di=%h int_n=%b bk_req=%b want di=e8 int_n=1 bk_req=0", cpu_di, int_n, bk_req);
        end
        @(posedge clk); #1;
        idle_pins();
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_di !== 8'hFF) begin errors++; $display("FAIL intack_release: got di=%h want ff", cpu_di); end

        // Second edge lands on the very clock that clears the pending flag.
        @(posedge clk); #1;
        irq = 1'b1;
        @(posedge clk); #1;
        irq = 1'b0;
        @(posedge clk); #1;
        m1_n = 1'b0; iorq_n = 1'b0; irq = 1'b1; irq_vec = 8'h3A;
        repeat (2) @(negedge clk);
        checks++;
        if ({int_n, cpu_di, bk_req} !== {1'b0, 8'h3A, 1'b0}) begin
            errors++;
            $display("FAIL irq_set_wins: got int_n=%b di=%h bk_req=%b want int_n=0 di=3a bk_req=0", int_n, cpu_di, bk_req);
        end
        @(posedge clk); #1;
        idle_pins();
        irq = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        m1_n = 1'b1; mreq_n = 1'b0; rd_n = 1'b0; a = 16'h2000;
        wait_bk_req("abort");
        @(posedge clk); #1;
        idle_pins();
        @(negedge clk);
        checks++;
        if ({wait_n, bk_req} !== 2'b11) begin
            errors++;
            $display("FAIL abort_release: got wait_n=%b bk_req=%b want wait_n=1 bk_req=1", wait_n, bk_req);
        end
        drive_access(1'b0, 1'b0, 16'h2100, 8'h00, 1);
        @(negedge clk);
        checks++;
        if ({wait_n, bk_req} !== 2'b01) begin
            errors++;
            $display("FAIL abort_hold: got wait_n=%b bk_req=%b want wait_n=0 bk_req=1", wait_n, bk_req);
        end
        bk_ack = 1'b1;
        bk_rdata = 8'h55;
        @(negedge clk);
        bk_ack = 1'b0;
        checks++;
        if ({cpu_di, wait_n, bk_req} !== {8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_discard: got di=%h wait_n=%b bk_req=%b want di=ff wait_n=0 bk_req=0", cpu_di, wait_n, bk_req);
        end
        finish_access("abort_next", 0);
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0; a = 16'h55AA; cpu_dout = 8'h99;
        wait_bk_req("reset_mid_req");
        idle_pins();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_di, wait_n, int_n, bk_req, bk_we, bk_io, bk_addr, bk_wdata} !==
            {8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_req: got di=%h wait_n=%b int_n=%b req=%b we=%b io=%b addr=%h wdata=%h want ff 1 1 0 0 0 0000 00",
                     cpu_di, wait_n, int_n, bk_req, bk_we, bk_io, bk_addr, bk_wdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 256; n++) begin
            logic        io, we;
            logic [15:0] addr;
            logic [7:0]  wd;
            int          lat;
            io   = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 16'h4000 | 16'($urandom_range(0, 15));
            wd   = 8'($urandom_range(0, 255));
            lat  = int'($urandom_range(0, 7));
            drive_access(io, we, addr, wd, lat);
            finish_access("b2b", 1);
        end
    endtask

    task automatic test_memcheck();
        foreach (ref_mem[key]) begin
            checks++;
            if (dev_rd(key) !== ref_mem[key]) begin
                errors++;
                $display("FAIL memcheck key=%h: got %h want %h", key, dev_rd(key), ref_mem[key]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_refresh();
        test_irq();
        test_abort();
        test_reset_mid_req();
        test_back_to_back();
        test_memcheck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
